// File: rtl/game_seq_ctrl.sv
// Round sequencer for the factorization game: times question/input/result
// phases, tracks scores and rounds, and declares WIN/LOSE at the target score.
module game_seq_ctrl #(
  parameter int Q_CYCLES   = 100,
  parameter int IN_CYCLES  = 1000,
  parameter int RES_CYCLES = 50,
  parameter int JDG_CYCLES = 16,
  parameter int WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       QUE_OK,
  input  logic       DEC,
  input  logic       JUDGE_VALID,
  input  logic       JUDGE_OK,
  input  logic       OPP_DONE,
  output logic [3:0] STATE,
  output logic       NEXT_Q,
  output logic [2:0] MY_SCORE,
  output logic [2:0] OPP_SCORE,
  output logic [3:0] ROUND
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    READY    = 4'b0010,
    QUESTION = 4'b0011,
    INPUT    = 4'b0100,
    JUDGE    = 4'b0101,
    DRAW     = 4'b0110,
    WRONG    = 4'b0111,
    GOOD     = 4'b1000,
    OUCH     = 4'b1001,
    WIN      = 4'b1010,
    LOSE     = 4'b1011
  } state_t;

  localparam int QW = $clog2(Q_CYCLES + 1);
  localparam int IW = $clog2(IN_CYCLES + 1);
  localparam int RW = $clog2(RES_CYCLES + 1);
  localparam int JW = $clog2(JDG_CYCLES + 1);

  localparam logic [QW-1:0] Q_LOAD   = QW'(Q_CYCLES - 1);
  localparam logic [IW-1:0] IN_LOAD  = IW'(IN_CYCLES);
  localparam logic [RW-1:0] RES_LOAD = RW'(RES_CYCLES - 1);
  localparam logic [JW-1:0] JDG_LOAD = JW'(JDG_CYCLES - 1);
  localparam logic [2:0]    WIN_SC   = 3'(WIN_SCORE);

  state_t        state_q, state_d;
  logic [QW-1:0] q_tmr_q, q_tmr_d;
  logic [IW-1:0] in_tmr_q, in_tmr_d, in_dec;
  logic [RW-1:0] res_tmr_q, res_tmr_d;
  logic [JW-1:0] jdg_tmr_q, jdg_tmr_d;
  logic [2:0]    my_score_q, my_score_d;
  logic [2:0]    opp_score_q, opp_score_d;
  logic [3:0]    round_q, round_d;
  logic          next_q_q, next_q_d;
  logic          opp_lat_q, opp_lat_d;

  assign in_dec = (in_tmr_q == '0) ? '0 : in_tmr_q - IW'(1);

  always_comb begin
    state_d     = state_q;
    q_tmr_d     = q_tmr_q;
    in_tmr_d    = in_tmr_q;
    res_tmr_d   = res_tmr_q;
    jdg_tmr_d   = jdg_tmr_q;
    my_score_d  = my_score_q;
    opp_score_d = opp_score_q;
    round_d     = round_q;
    next_q_d    = 1'b0;
    opp_lat_d   = opp_lat_q;

    case (state_q)
      IDLE: if (START) state_d = READY;
      READY: if (QUE_OK) begin
        state_d = QUESTION;
        q_tmr_d = Q_LOAD;
      end
      QUESTION: begin
        if (q_tmr_q == '0) begin
          state_d  = INPUT;
          in_tmr_d = IN_LOAD;
        end else begin
          q_tmr_d = q_tmr_q - QW'(1);
        end
      end
      INPUT: begin
        in_tmr_d = in_dec;
        if (OPP_DONE) opp_lat_d = 1'b1;
        if (DEC) begin
          state_d   = JUDGE;
          jdg_tmr_d = JDG_LOAD;
        end else if (OPP_DONE) begin
          state_d = OUCH;
        end else if (in_tmr_q <= IW'(1)) begin
          state_d = DRAW;
        end
      end
      JUDGE: begin
        in_tmr_d = in_dec;
        if (OPP_DONE) opp_lat_d = 1'b1;
        // A correct answer wins even if the opponent also finished meanwhile
        if (JUDGE_VALID) state_d = JUDGE_OK ? GOOD : WRONG;
        else if (jdg_tmr_q == '0) state_d = WRONG;
        else jdg_tmr_d = jdg_tmr_q - JW'(1);
      end
      WRONG: begin
        if (OPP_DONE) opp_lat_d = 1'b1;
        if (res_tmr_q == '0) begin
          if (opp_lat_q || OPP_DONE) state_d = OUCH;
          else if (in_tmr_q == '0)   state_d = DRAW;
          else                       state_d = INPUT;
        end else begin
          res_tmr_d = res_tmr_q - RW'(1);
        end
      end
      GOOD: begin
        if (res_tmr_q == '0) state_d = (my_score_q == WIN_SC) ? WIN : READY;
        else res_tmr_d = res_tmr_q - RW'(1);
      end
      OUCH: begin
        if (res_tmr_q == '0) state_d = (opp_score_q == WIN_SC) ? LOSE : READY;
        else res_tmr_d = res_tmr_q - RW'(1);
      end
      DRAW: begin
        if (res_tmr_q == '0) state_d = READY;
        else res_tmr_d = res_tmr_q - RW'(1);
      end
      WIN, LOSE: if (START) state_d = READY;
      default: state_d = IDLE;
    endcase

    // Entry actions are applied once, on the cycle the state changes
    if (state_d != state_q) begin
      case (state_d)
        READY: begin
          next_q_d  = 1'b1;
          opp_lat_d = 1'b0;
          if (state_q == IDLE || state_q == WIN || state_q == LOSE) begin
            my_score_d  = '0;
            opp_score_d = '0;
            round_d     = '0;
          end
        end
        GOOD: begin
          my_score_d = (my_score_q == 3'd7) ? 3'd7 : my_score_q + 3'd1;
          round_d    = round_q + 4'd1;
          res_tmr_d  = RES_LOAD;
        end
        OUCH: begin
          opp_score_d = (opp_score_q == 3'd7) ? 3'd7 : opp_score_q + 3'd1;
          round_d     = round_q + 4'd1;
          res_tmr_d   = RES_LOAD;
        end
        DRAW: begin
          round_d   = round_q + 4'd1;
          res_tmr_d = RES_LOAD;
        end
        WRONG: res_tmr_d = RES_LOAD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      q_tmr_q     <= '0;
      in_tmr_q    <= '0;
      res_tmr_q   <= '0;
      jdg_tmr_q   <= '0;
      my_score_q  <= '0;
      opp_score_q <= '0;
      round_q     <= '0;
      next_q_q    <= 1'b0;
      opp_lat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_tmr_q     <= q_tmr_d;
      in_tmr_q    <= in_tmr_d;
      res_tmr_q   <= res_tmr_d;
      jdg_tmr_q   <= jdg_tmr_d;
      my_score_q  <= my_score_d;
      opp_score_q <= opp_score_d;
      round_q     <= round_d;
      next_q_q    <= next_q_d;
      opp_lat_q   <= opp_lat_d;
    end
  end

  assign STATE     = state_q;
  assign NEXT_Q    = next_q_q;
  assign MY_SCORE  = my_score_q;
  assign OPP_SCORE = opp_score_q;
  assign ROUND     = round_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Scoreboard bench for game_seq_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared just after each rising clock edge.
module tb_game_seq_ctrl;

  localparam logic [3:0] S_IDLE     = 4'b0000;
  localparam logic [3:0] S_READY    = 4'b0010;
  localparam logic [3:0] S_QUESTION = 4'b0011;
  localparam logic [3:0] S_INPUT    = 4'b0100;
  localparam logic [3:0] S_JUDGE    = 4'b0101;
  localparam logic [3:0] S_DRAW     = 4'b0110;
  localparam logic [3:0] S_WRONG    = 4'b0111;
  localparam logic [3:0] S_GOOD     = 4'b1000;
  localparam logic [3:0] S_OUCH     = 4'b1001;
  localparam logic [3:0] S_WIN      = 4'b1010;

  logic       CLK = 1'b0;
  logic       RST, START, QUE_OK, DEC, JUDGE_VALID, JUDGE_OK, OPP_DONE;
  logic [3:0] STATE, ROUND;
  logic       NEXT_Q;
  logic [2:0] MY_SCORE, OPP_SCORE;

  int compare_count  = 0;
  int mismatch_count = 0;

  logic [2:0] exp_my, exp_opp;
  logic [3:0] exp_round;
  logic [14:0] exp_q[$];
  string       tag_q[$];

  game_seq_ctrl #(
    .Q_CYCLES(4), .IN_CYCLES(20), .RES_CYCLES(3), .JDG_CYCLES(5), .WIN_SCORE(2)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .QUE_OK(QUE_OK), .DEC(DEC),
    .JUDGE_VALID(JUDGE_VALID), .JUDGE_OK(JUDGE_OK), .OPP_DONE(OPP_DONE),
    .STATE(STATE), .NEXT_Q(NEXT_Q), .MY_SCORE(MY_SCORE),
    .OPP_SCORE(OPP_SCORE), .ROUND(ROUND)
  );

  always #5 CLK = ~CLK;

  // Compares {STATE, NEXT_Q, MY_SCORE, OPP_SCORE, ROUND} as one word
  task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    compare_count++;
    if (obs !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got st=%b nq=%b my=%0d opp=%0d rnd=%0d, need st=%b nq=%b my=%0d opp=%0d rnd=%0d",
               tag, obs[14:11], obs[10], obs[9:7], obs[6:4], obs[3:0],
               exp[14:11], exp[10], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  // Queue what the outputs must be after the next edge, then step one cycle
  task automatic applyStimulus(input string tag, input logic [3:0] st, input logic nq);
    exp_q.push_back({st, nq, exp_my, exp_opp, exp_round});
    tag_q.push_back(tag);
    @(posedge CLK);
    #2;
  endtask

  task automatic enterRound(input string tag);
    QUE_OK = 1'b1;
    applyStimulus({tag, "_q"}, S_QUESTION, 1'b0);
    QUE_OK = 1'b0;
    repeat (3) applyStimulus({tag, "_q"}, S_QUESTION, 1'b0);
    applyStimulus({tag, "_in"}, S_INPUT, 1'b0);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      checkOutput(tag_q.pop_front(), {STATE, NEXT_Q, MY_SCORE, OPP_SCORE, ROUND}, exp_q.pop_front());
    end
  end

  initial begin
    RST = 1'b0; START = 1'b0; QUE_OK = 1'b0; DEC = 1'b0;
    JUDGE_VALID = 1'b0; JUDGE_OK = 1'b0; OPP_DONE = 1'b0;
    exp_my = '0; exp_opp = '0; exp_round = '0;
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset", {STATE, NEXT_Q, MY_SCORE, OPP_SCORE, ROUND}, {S_IDLE, 1'b0, 3'd0, 3'd0, 4'd0});
    RST = 1'b1;
    applyStimulus("idle_hold", S_IDLE, 1'b0);

    START = 1'b1;
    applyStimulus("t1_ready", S_READY, 1'b1);
    START = 1'b0;
    enterRound("t1");

    DEC = 1'b1;
    applyStimulus("t2_judge", S_JUDGE, 1'b0);
    DEC = 1'b0;
    applyStimulus("t2_judge", S_JUDGE, 1'b0);
    JUDGE_VALID = 1'b1; JUDGE_OK = 1'b1;
    exp_my = 3'd1; exp_round = 4'd1;
    applyStimulus("t2_good", S_GOOD, 1'b0);
    JUDGE_VALID = 1'b0; JUDGE_OK = 1'b0;
    repeat (2) applyStimulus("t2_good", S_GOOD, 1'b0);
    applyStimulus("t2_ready", S_READY, 1'b1);
    enterRound("t2");

    DEC = 1'b1; OPP_DONE = 1'b1;
    applyStimulus("t3_judge", S_JUDGE, 1'b0);
    DEC = 1'b0; OPP_DONE = 1'b0;
    JUDGE_VALID = 1'b1;
    applyStimulus("t3_wrong", S_WRONG, 1'b0);
    JUDGE_VALID = 1'b0;
    repeat (2) applyStimulus("t3_wrong", S_WRONG, 1'b0);
    exp_opp = 3'd1; exp_round = 4'd2;
    repeat (3) applyStimulus("t3_ouch", S_OUCH, 1'b0);
    applyStimulus("t3_ready", S_READY, 1'b1);
    enterRound("t3");

    repeat (19) applyStimulus("t4_input", S_INPUT, 1'b0);
    exp_round = 4'd3;
    repeat (3) applyStimulus("t4_draw", S_DRAW, 1'b0);
    applyStimulus("t4_ready", S_READY, 1'b1);
    enterRound("t4");

    DEC = 1'b1;
    applyStimulus("t5_judge", S_JUDGE, 1'b0);
    DEC = 1'b0;
    repeat (4) applyStimulus("t5_judge", S_JUDGE, 1'b0);
    repeat (3) applyStimulus("t5_wrong", S_WRONG, 1'b0);
    repeat (14) applyStimulus("t5_resume", S_INPUT, 1'b0);
    exp_round = 4'd4;
    repeat (3) applyStimulus("t5_draw", S_DRAW, 1'b0);
    applyStimulus("t5_ready", S_READY, 1'b1);
    enterRound("t5");

    DEC = 1'b1;
    applyStimulus("t6_judge", S_JUDGE, 1'b0);
    DEC = 1'b0;
    JUDGE_VALID = 1'b1; JUDGE_OK = 1'b1;
    exp_my = 3'd2; exp_round = 4'd5;
    applyStimulus("t6_good", S_GOOD, 1'b0);
    JUDGE_VALID = 1'b0; JUDGE_OK = 1'b0;
    repeat (2) applyStimulus("t6_good", S_GOOD, 1'b0);
    repeat (4) applyStimulus("t6_win", S_WIN, 1'b0);
    START = 1'b1;
    exp_my = '0; exp_opp = '0; exp_round = '0;
    applyStimulus("t6_restart", S_READY, 1'b1);
    enterRound("t6");
    applyStimulus("t6_input", S_INPUT, 1'b0);
    START = 1'b0;
    applyStimulus("t6_input", S_INPUT, 1'b0);

    RST = 1'b0;
    #1;
    checkOutput("async_rst", {STATE, NEXT_Q, MY_SCORE, OPP_SCORE, ROUND}, {S_IDLE, 1'b0, 3'd0, 3'd0, 4'd0});
    @(posedge CLK);
    #2;
    RST = 1'b1;
    applyStimulus("post_rst", S_IDLE, 1'b0);
    applyStimulus("post_rst", S_IDLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/game_seq_ctrl.md
Name: game_seq_ctrl

Overview:
- Top-level round sequencer for the factorization game.
- Drives the 4-bit STATE bus consumed by the input, display and question blocks.
- Times the question display, input window and result display.
- Keeps player/opponent scores and rounds; declares WIN/LOSE when a score reaches the target.

Parameters:
- Q_CYCLES, 100, cycles the QUESTION state is held before INPUT.
- IN_CYCLES, 1000, input-window length in cycles (timeout to DRAW).
- RES_CYCLES, 50, cycles each result state (WRONG/GOOD/OUCH/DRAW) is held.
- JDG_CYCLES, 16, maximum wait for a judge response.
- WIN_SCORE, 3, score that ends the match (1..7).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- START  in  1  level; begins a match from IDLE or restarts from WIN/LOSE.
- QUE_OK  in  1  question-ready flag from the input block.
- DEC  in  1  one-cycle answer-decide pulse (already synchronised).
- JUDGE_VALID  in  1  one-cycle pulse: answer check result available.
- JUDGE_OK  in  1  answer correct; qualified by JUDGE_VALID.
- OPP_DONE  in  1  one-cycle pulse: opponent answered correctly.
- STATE  out  4  current state code.
- NEXT_Q  out  1  one-cycle request for a new question.
- MY_SCORE  out  3  player score.
- OPP_SCORE  out  3  opponent score.
- ROUND  out  4  completed rounds; wraps 15->0.

Behaviour:
- Reset (RST low, async): STATE=IDLE, NEXT_Q=0, scores=0, ROUND=0, all timers 0, opp-latch cleared.
- All outputs are registered and change only on CLK rising edges.
- State codes: IDLE 0000, READY 0010, QUESTION 0011, INPUT 0100, JUDGE 0101, DRAW 0110, WRONG 0111, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011. No other codes are ever driven; any illegal value recovers to IDLE on the next cycle.
- IDLE:
  - START=1 -> READY; scores and ROUND are cleared.
- READY:
  - NEXT_Q=1 on the first cycle only.
  - QUE_OK=1 -> QUESTION.
- QUESTION:
  - Q-timer loads on entry; after exactly Q_CYCLES cycles in state -> INPUT.
  - IN-timer loads IN_CYCLES on this transition.
- INPUT (IN-timer decrements every cycle):
  - DEC=1 -> JUDGE. DEC wins over OPP_DONE and timeout in the same cycle.
  - Else OPP_DONE=1 -> OUCH.
  - Else IN-timer reaches 0 -> DRAW.
- JUDGE:
  - IN-timer keeps decrementing and saturates at 0.
  - An OPP_DONE pulse arriving here is latched.
  - JUDGE_VALID & JUDGE_OK -> GOOD, even if the opp-latch is set (player's DEC came first).
  - JUDGE_VALID & !JUDGE_OK -> WRONG.
  - No JUDGE_VALID within JDG_CYCLES cycles -> WRONG.
- WRONG (held RES_CYCLES):
  - Exit -> OUCH if opp-latch set or OPP_DONE seen during WRONG.
  - Else DRAW if IN-timer = 0.
  - Else INPUT; IN-timer resumes and is not reloaded.
- GOOD:
  - MY_SCORE+1 on entry.
  - Held RES_CYCLES, then WIN if MY_SCORE==WIN_SCORE, else READY.
- OUCH:
  - OPP_SCORE+1 on entry.
  - Held RES_CYCLES, then LOSE if OPP_SCORE==WIN_SCORE, else READY.
- DRAW:
  - No score change; held RES_CYCLES -> READY.
- Round bookkeeping:
  - ROUND+1 on entry to GOOD, OUCH and DRAW (once per round).
  - Opp-latch clears on entry to READY.
- WIN / LOSE:
  - Held indefinitely. START=1 -> READY with scores and ROUND cleared.
  - START held high does not re-trigger while in READY..LOSE.
- Scores saturate at 7. The result-hold counter is shared between result states and reloads on every entry.
- Reset mid-round returns to IDLE immediately, with no NEXT_Q pulse.

Test Plan:
Use Q_CYCLES=4, IN_CYCLES=20, RES_CYCLES=3, JDG_CYCLES=5, WIN_SCORE=2.
1. Reset, START pulse, QUE_OK=1 -> STATE 0000->0010 (NEXT_Q=1 for 1 cycle)->0011 for 4 cycles->0100.
2. In INPUT: DEC, then JUDGE_VALID=1 & JUDGE_OK=1 two cycles later -> 0101->1000 for 3 cycles, MY_SCORE=1, ROUND=1, ->0010.
3. In INPUT: DEC and OPP_DONE in the same cycle, then JUDGE_VALID=1 & JUDGE_OK=0 -> 0101->0111 for 3 cycles->1001, OPP_SCORE+1.
4. In INPUT: no input for 20 cycles -> 0110 for 3 cycles->0010, ROUND+1, scores unchanged.
5. DEC with no JUDGE_VALID -> WRONG after 5 cycles -> back to 0100 with the IN-timer not reloaded.
6. Two GOOD rounds -> 1010 held while START=0. START=1 -> 0010 with MY_SCORE=0, ROUND=0. RST low mid-INPUT -> 0000 immediately (asynchronous).
